spi_master_param: RTL and testbench
===================================

// Module: spi_master_param
// PURPOSE
//  Parametrised SPI master with a memory-mapped slave port (chip_select/write/writedata/readdata) that drives the SD-card SPI pins.
//  Supersedes the fixed-function SPI link: frame width is parametric, the SCLK divider is programmable at run time,
//  all four CPOL/CPHA modes are supported, and there is a multi-slave chip-select with auto or manual control.
//  Sits between the CPU bus and the SD card / SPI peripherals.
// PARAMETERS
//  DATA_W      8    bits per frame (legal range 4..32), sent MSB first
//  DIV_W       8    width of the SCLK half-period divider field
//  DEFAULT_DIV 124  divider value after reset (slow SD-init clock)
//  NUM_CS      1    number of chip-select outputs (legal range 1..8)
// PORTS
//  clk          in   1        system clock; all logic on its rising edge
//  reset        in   1        synchronous, active-high reset
//  address      in   2        register select: 0=DATA, 1=CTRL, 2=STATUS, 3=reads 0
//  chip_select  in   1        bus access strobe; a read is chip_select & ~write
//  write        in   1        write strobe, qualified by chip_select
//  writedata    in   32       write data
//  readdata     out  32       registered read data, valid the cycle after the access
//  SD_CLK       out  1        SCLK
//  SD_MOSI      out  1        master out
//  SD_MISO      in   1        master in
//  SD_CS        out  NUM_CS   active-low chip selects
// BEHAVIOUR
//  Reset values: SD_CLK=0, SD_MOSI=1, SD_CS=all 1, readdata=0, state=IDLE, div=DEFAULT_DIV, CPOL=CPHA=0, manual=0, busy/rx_valid/overrun=0.
//  Reset is synchronous; taking effect mid-transfer aborts the frame in the same cycle and RX data is discarded.
//  CTRL register: [DIV_W-1:0] div; [16] CPOL; [17] CPHA; [18] CS_MANUAL; [19] CS_ASSERT; [26:24] cs_sel.
//   - A CTRL write while busy is ignored entirely.
//   - cs_sel >= NUM_CS selects no slave: all SD_CS stay high, but the transfer still runs.
//  STATUS register: [0] busy; [1] rx_valid; [2] overrun. The upper bits read 0.
//  DATA write (address 0):
//   - In IDLE: latches writedata[DATA_W-1:0], sets busy, enters SETUP.
//   - While busy: ignored and sets overrun.
//  DATA read: returns the RX shift value zero-extended to 32 bits, and clears rx_valid and overrun.
//  Half-period H = div+1 clk cycles; div=0 gives SCLK=clk/2.
//  SD_CLK idles at CPOL; it is updated to the new CPOL in IDLE only.
//  FSM:
//   - IDLE: wait for a DATA write.
//   - SETUP: 1 H. In auto mode, SD_CS[cs_sel]=0. SD_MOSI drives the MSB if CPHA=0.
//   - XFER: 2*DATA_W half-periods, toggling SD_CLK at the end of each H.
//     CPHA=0: sample MISO on leading edges; shift MOSI on trailing edges (no shift after the last).
//     CPHA=1: shift MOSI on leading edges (first leading edge presents the MSB); sample on trailing edges.
//   - HOLD: 1 H, SD_CLK=CPOL, CS still asserted. At the end: SD_CS deasserts (auto), busy=0, rx_valid=1, SD_MOSI=1, go to IDLE.
//  Total busy = (2*DATA_W+2)*H cycles, counted from the cycle after the DATA write.
//  Manual CS (CS_MANUAL=1): SD_CS[cs_sel]=~CS_ASSERT at all times; the FSM never touches CS. This allows multi-frame bursts.
//  A DATA write in the same cycle busy clears (last HOLD cycle) counts as busy: ignored, overrun set.
//  A DATA read in the same cycle rx_valid sets: the read returns new data, and rx_valid ends at 1.
//  MISO is sampled with no extra synchroniser; the bench drives it clean.
// TESTING
//  1. Mode 0, div=1, write DATA 0xA5, MISO slave returns 0x3C:
//     MOSI=1,0,1,0,0,1,0,1; 8 rising SCLK edges; busy for exactly 36 cycles; DATA read=0x0000003C; rx_valid then 0.
//  2. Mode 3 (CPOL=1, CPHA=1), div=0, write 0x81, MISO constant 1:
//     SD_CLK idles high; 8 rising edges; RX=0xFF; busy for 18 cycles.
//  3. A second DATA write (0x55) 5 cycles into a transfer of 0x12:
//     MOSI still carries 0x12; overrun=1; the next transfer must be started explicitly.
//  4. Manual CS, cs_sel=0, CS_ASSERT=1, two writes 0x40 then 0x00 with no CTRL write between:
//     SD_CS[0] stays low across both frames and the gap; it rises only after CS_ASSERT=0.
//  5. reset asserted mid-XFER (bit 3):
//     next cycle SD_CS=all 1, SD_CLK=0, SD_MOSI=1, STATUS=0, div reads 124.
//  6. CTRL write div=3 while busy is ignored (div unchanged); cs_sel=5 with NUM_CS=1 runs the transfer with SD_CS=1 throughout.

Source files
------------

// File: rtl/spi_master_param.sv
// Parametrised SPI master with a bus slave port.
// Programmable divider, CPOL/CPHA, and auto or manual chip selects.
module spi_master_param #(
  parameter int DATA_W      = 8,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 124,
  parameter int NUM_CS      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chip_select,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              SD_CLK,
  output logic              SD_MOSI,
  input  logic              SD_MISO,
  output logic [NUM_CS-1:0] SD_CS
);

  localparam int HW = $clog2(2 * DATA_W);
  localparam logic [HW-1:0] LAST = HW'(2 * DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t state_q, state_d;

  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  cnt_q;
  logic [HW-1:0]     hcnt_q;
  logic              cpol_q;
  logic              cpha_q;
  logic              manual_q;
  logic              cs_assert_q;
  logic [2:0]        cs_sel_q;
  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] rx_q;
  logic              rx_valid_q;
  logic              overrun_q;
  logic              cs_act_q;
  logic              sclk_q;
  logic              mosi_q;
  logic [31:0]       rd_mux;

  logic busy, tick, data_wr, ctrl_wr, rd;
  logic lead, sample, last;

  assign busy    = (state_q != IDLE);
  assign tick    = (cnt_q == div_q);
  assign data_wr = chip_select & write & (address == 2'd0);
  assign ctrl_wr = chip_select & write & (address == 2'd1);
  assign rd      = chip_select & ~write;
  assign lead    = ~hcnt_q[0];
  assign sample  = lead ^ cpha_q;
  assign last    = (hcnt_q == LAST);

  assign SD_CLK  = sclk_q;
  assign SD_MOSI = mosi_q;

  always_comb begin
    SD_CS = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_sel_q == 3'(i))
        SD_CS[i] = ~(manual_q ? cs_assert_q : cs_act_q);
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (address)
      2'd0: rd_mux = 32'(rx_q);
      2'd1: begin
        rd_mux[DIV_W-1:0] = div_q;
        rd_mux[16]        = cpol_q;
        rd_mux[17]        = cpha_q;
        rd_mux[18]        = manual_q;
        rd_mux[19]        = cs_assert_q;
        rd_mux[26:24]     = cs_sel_q;
      end
      2'd2: rd_mux[2:0] = {overrun_q, rx_valid_q, busy};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (data_wr) state_d = SETUP;
      SETUP: if (tick) state_d = XFER;
      XFER:  if (tick && last) state_d = HOLD;
      HOLD:  if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q       <= DIV_W'(DEFAULT_DIV);
      cnt_q       <= '0;
      hcnt_q      <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      manual_q    <= 1'b0;
      cs_assert_q <= 1'b0;
      cs_sel_q    <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      cs_act_q    <= 1'b0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b1;
      readdata    <= '0;
    end else begin
      if (rd) readdata <= rd_mux;
      if (rd && address == 2'd0) begin
        rx_valid_q <= 1'b0;
        overrun_q  <= 1'b0;
      end
      if (data_wr && busy) overrun_q <= 1'b1;
      if (ctrl_wr && !busy) begin
        div_q       <= writedata[DIV_W-1:0];
        cpol_q      <= writedata[16];
        cpha_q      <= writedata[17];
        manual_q    <= writedata[18];
        cs_assert_q <= writedata[19];
        cs_sel_q    <= writedata[26:24];
      end

      if (!busy || tick) cnt_q <= '0;
      else               cnt_q <= cnt_q + DIV_W'(1);

      unique case (state_q)
        IDLE: begin
          sclk_q <= cpol_q;
          mosi_q <= 1'b1;
          if (data_wr) begin
            tx_q     <= writedata[DATA_W-1:0];
            hcnt_q   <= '0;
            cs_act_q <= 1'b1;
            if (!cpha_q) mosi_q <= writedata[DATA_W-1];
          end
        end
        SETUP: ;
        XFER: begin
          if (tick) begin
            sclk_q <= ~sclk_q;
            hcnt_q <= hcnt_q + HW'(1);
            if (sample) begin
              rx_q <= {rx_q[DATA_W-2:0], SD_MISO};
            end else if (cpha_q) begin
              mosi_q <= tx_q[DATA_W-1];
              tx_q   <= tx_q << 1;
            end else if (!last) begin
              mosi_q <= tx_q[DATA_W-2];
              tx_q   <= tx_q << 1;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            cs_act_q   <= 1'b0;
            rx_valid_q <= 1'b1;
            mosi_q     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param with an SPI slave model
// and a queue scoreboard for MOSI frames and DATA reads.
module tb_spi_master_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chip_select;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        SD_CLK;
  logic        SD_MOSI;
  logic        SD_MISO;
  logic [0:0]  SD_CS;

  spi_master_param dut (
    .clk(clk), .reset(reset), .address(address),
    .chip_select(chip_select), .write(write),
    .writedata(writedata), .readdata(readdata),
    .SD_CLK(SD_CLK), .SD_MOSI(SD_MOSI),
    .SD_MISO(SD_MISO), .SD_CS(SD_CS)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  logic [7:0]  slv_tx, slv_rx;
  int          slv_bits, rises;
  logic        prev_clk, tb_cpol, tb_cpha, mon_en;
  logic        exp_cs;
  logic [7:0]  exp_mosi_q[$];
  logic [31:0] exp_rd_q[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    logic lead;
    if (SD_CLK !== prev_clk) begin
      lead = (prev_clk == tb_cpol);
      if (SD_CLK) rises++;
      if (lead ^ tb_cpha) begin
        check("cs_during", {31'b0, SD_CS}, {31'b0, exp_cs});
        slv_rx = {slv_rx[6:0], SD_MOSI};
        slv_bits++;
        if (slv_bits == 8) begin
          slv_bits = 0;
          if (exp_mosi_q.size() == 0)
            check("mosi_unexpected", {24'b0, slv_rx}, 32'hDEAD);
          else
            check("mosi_frame", {24'b0, slv_rx}, {24'b0, exp_mosi_q.pop_front()});
        end
      end else if (tb_cpha) begin
        SD_MISO = slv_tx[7];
        slv_tx = slv_tx << 1;
      end else begin
        slv_tx = slv_tx << 1;
        SD_MISO = slv_tx[7];
      end
      prev_clk = SD_CLK;
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (mon_en) mon();
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    chip_select = 1'b1; write = 1'b1; address = a; writedata = d;
    step();
    chip_select = 1'b0; write = 1'b0;
  endtask

  task automatic rd(logic [1:0] a, output logic [31:0] d);
    chip_select = 1'b1; write = 1'b0; address = a;
    step();
    chip_select = 1'b0;
    d = readdata;
  endtask

  task automatic config_ctrl(logic [31:0] d);
    mon_en = 1'b0;
    wr(2'd1, d);
    step();
    step();
    tb_cpol = d[16];
    tb_cpha = d[17];
    prev_clk = SD_CLK;
    rises = 0;
    slv_bits = 0;
    mon_en = 1'b1;
  endtask

  task automatic slave_load(logic [7:0] b);
    slv_tx = b;
    SD_MISO = b[7];
  endtask

  task automatic wait_idle(output int bc);
    bit seen;
    seen = 0;
    bc = 0;
    chip_select = 1'b1; write = 1'b0; address = 2'd2;
    for (int i = 0; i < 5000; i++) begin
      step();
      if (readdata[0]) begin
        seen = 1;
        bc++;
      end else if (seen) break;
    end
    chip_select = 1'b0;
    check("idle_reached", {31'b0, readdata[0]}, 32'd0);
  endtask

  logic [31:0] d;
  int bc;

  initial begin
    reset = 1'b1; address = '0; chip_select = 1'b0; write = 1'b0;
    writedata = '0; SD_MISO = 1'b0; mon_en = 1'b0;
    tb_cpol = 1'b0; tb_cpha = 1'b0; exp_cs = 1'b0;
    slv_tx = '0; slv_rx = '0; slv_bits = 0; rises = 0;
    step();
    step();
    reset = 1'b0;
    step();
    prev_clk = SD_CLK;

    check("rst_readdata", readdata, 32'd0);
    check("rst_pins", {29'b0, SD_CLK, SD_MOSI, SD_CS}, 32'b011);
    rd(2'd2, d); check("rst_status", d, 32'd0);
    rd(2'd1, d); check("rst_ctrl", d, 32'd124);

    // Mode 0, div=1
    config_ctrl(32'h0000_0001);
    exp_cs = 1'b0;
    slave_load(8'h3C);
    exp_mosi_q.push_back(8'hA5);
    exp_rd_q.push_back(32'h3C);
    wr(2'd0, 32'hA5);
    wait_idle(bc);
    check("m0_busy", bc, 36);
    check("m0_rises", rises, 8);
    check("m0_mosi_left", exp_mosi_q.size(), 0);
    rd(2'd2, d); check("m0_status_valid", d, 32'd2);
    rd(2'd0, d); check("m0_rx", d, exp_rd_q.pop_front());
    rd(2'd2, d); check("m0_status_clr", d, 32'd0);
    check("m0_cs_idle", {31'b0, SD_CS}, 32'd1);

    // Mode 3, div=0
    config_ctrl(32'h0003_0000);
    check("m3_idle_clk", {31'b0, SD_CLK}, 32'd1);
    slave_load(8'hFF);
    SD_MISO = 1'b1;
    exp_mosi_q.push_back(8'h81);
    exp_rd_q.push_back(32'hFF);
    wr(2'd0, 32'h81);
    wait_idle(bc);
    check("m3_busy", bc, 18);
    check("m3_rises", rises, 8);
    rd(2'd0, d); check("m3_rx", d, exp_rd_q.pop_front());
    check("m3_end_clk", {31'b0, SD_CLK}, 32'd1);

    // Overrun: second write mid-transfer is dropped
    config_ctrl(32'h0000_0001);
    slave_load(8'h00);
    exp_mosi_q.push_back(8'h12);
    exp_rd_q.push_back(32'h00);
    wr(2'd0, 32'h12);
    for (int i = 0; i < 4; i++) step();
    wr(2'd0, 32'h55);
    wait_idle(bc);
    check("ovr_mosi_left", exp_mosi_q.size(), 0);
    rd(2'd2, d); check("ovr_status", d, 32'd6);
    rd(2'd0, d); check("ovr_rx", d, exp_rd_q.pop_front());
    step(); step(); step();
    rd(2'd2, d); check("ovr_no_restart", d, 32'd0);

    // Manual CS burst
    config_ctrl(32'h000C_0001);
    check("man_cs_on", {31'b0, SD_CS}, 32'd0);
    slave_load(8'h00);
    exp_mosi_q.push_back(8'h40);
    exp_rd_q.push_back(32'h00);
    wr(2'd0, 32'h40);
    wait_idle(bc);
    check("man_cs_gap", {31'b0, SD_CS}, 32'd0);
    rd(2'd0, d); check("man_rx0", d, exp_rd_q.pop_front());
    check("man_cs_gap2", {31'b0, SD_CS}, 32'd0);
    slave_load(8'h00);
    exp_mosi_q.push_back(8'h00);
    exp_rd_q.push_back(32'h00);
    wr(2'd0, 32'h00);
    wait_idle(bc);
    check("man_cs_after", {31'b0, SD_CS}, 32'd0);
    rd(2'd0, d); check("man_rx1", d, exp_rd_q.pop_front());
    config_ctrl(32'h0004_0001);
    check("man_cs_off", {31'b0, SD_CS}, 32'd1);
    check("man_mosi_left", exp_mosi_q.size(), 0);

    // Reset in the middle of bit 3
    config_ctrl(32'h0000_0001);
    slave_load(8'h00);
    wr(2'd0, 32'hF0);
    for (int i = 0; i < 15; i++) step();
    check("rst_mid_cs_busy", {31'b0, SD_CS}, 32'd0);
    mon_en = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_pins", {29'b0, SD_CLK, SD_MOSI, SD_CS}, 32'b011);
    rd(2'd2, d); check("rst_mid_status", d, 32'd0);
    rd(2'd1, d); check("rst_mid_div", d, 32'd124);
    rd(2'd0, d); check("rst_mid_rx", d, 32'd0);

    // cs_sel out of range, CTRL write while busy ignored
    config_ctrl(32'h0500_0000);
    exp_cs = 1'b1;
    slave_load(8'h5A);
    exp_mosi_q.push_back(8'hAA);
    exp_rd_q.push_back(32'h5A);
    wr(2'd0, 32'hAA);
    step();
    step();
    wr(2'd1, 32'h0000_0003);
    wait_idle(bc);
    check("sel_busy_tail", bc, 15);
    check("sel_cs_high", {31'b0, SD_CS}, 32'd1);
    rd(2'd1, d); check("sel_ctrl_kept", d, 32'h0500_0000);
    rd(2'd0, d); check("sel_rx", d, exp_rd_q.pop_front());
    check("sel_mosi_left", exp_mosi_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
